clk_rst_gen: RTL and testbench

Parametrised clock-enable/divided-clock and reset-sequencing generator for FPGA top levels. It generalises the fixed divide-by-2 toggle flop and the single-output boot-reset counter to NUM_CH channels. Each channel has a runtime-programmable divisor, a sequenced staggered reset release, and a per-channel soft-reset request. It sits between the board reference clock and the controller/core domains.

---
 rtl/clk_rst_gen_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 68 ++++++
 rtl/clk_rst_gen.sv | 175 +++++++++++++++++
 tb/tb_clk_rst_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_gen_pkg.sv
// clk_rst_gen_pkg: shared types and helpers for the clock-enable / reset
// sequencing generator (clk_rst_gen and clk_div_channel).
package clk_rst_gen_pkg;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } seq_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel. Holds the active half-period, a
// pending half-period written through the config port, the cycle counter,
// the registered clock-enable pulse and the divided-clock toggle flop.
module clk_div_channel #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             pending_o,
    output logic             ce_o,
    output logic             clk_div_o
);

    localparam logic [DIV_W-1:0] DIV_RST = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             pend_q;
    logic             ce_q;
    logic             tgl_q;
    logic [DIV_W-1:0] div_wr;
    logic             tc;

    // Normalise a zero divisor to 1 and detect the terminal count.
    always_comb begin
        div_wr = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
        tc     = (cnt_q == (div_q - DIV_W'(1)));
    end

    // Counter, enable pulse and toggle; a pending divisor is swapped in only
    // at terminal count so the running half-period always completes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q      <= DIV_RST;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            ce_q       <= 1'b0;
            tgl_q      <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                pend_q     <= 1'b1;
                pend_div_q <= div_wr;
            end
            if (tc) begin
                cnt_q <= '0;
                ce_q  <= 1'b1;
                tgl_q <= ~tgl_q;
                if (pend_q) begin
                    div_q  <= pend_div_q;
                    pend_q <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
                ce_q  <= 1'b0;
            end
        end
    end

    assign pending_o = pend_q;
    assign ce_o      = ce_q;
    assign clk_div_o = tgl_q;

endmodule

// File: rtl/clk_rst_gen.sv
// clk_rst_gen: NUM_CH-channel divided-clock / clock-enable generator with a
// staggered power-up reset release sequencer and per-channel soft resets.
// Optional LED heartbeat output enabled by defining CLK_RST_GEN_HEARTBEAT_EN.
module clk_rst_gen
    import clk_rst_gen_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned DEFAULT_DIV  = 1,
    parameter int unsigned RESET_CYCLES = 20,
    parameter int unsigned STAGGER      = 4
`ifdef CLK_RST_GEN_HEARTBEAT_EN
    ,
    parameter int unsigned HB_BITS      = 24
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]          cfg_div,
    input  logic [NUM_CH-1:0]         soft_rst_req,
    output logic [NUM_CH-1:0]         clk_div_o,
    output logic [NUM_CH-1:0]         ce_o,
    output logic [NUM_CH-1:0]         rst_o,
    output logic                      ready_o
`ifdef CLK_RST_GEN_HEARTBEAT_EN
    ,
    output logic                      heartbeat_o
`endif
);

    localparam int unsigned CHW = ch_w(NUM_CH);
    localparam int unsigned HCW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SCW = $clog2(STAGGER + 1);

    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     ch_we;
    logic [(2**CHW)-1:0]   pend_ext;

    seq_state_t            state_q;
    logic [HCW-1:0]        hold_cnt_q;
    logic [SCW-1:0]        stag_cnt_q;
    logic [CHW-1:0]        idx_q;
    logic [NUM_CH-1:0]     hold_q;
    logic                  ready_q;

    logic [HCW-1:0]        soft_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]     soft_q;

    // Config handshake: a channel accepts a new divisor only when it has none
    // pending. Unpopulated channel indices read as ready and drop the write.
    always_comb begin
        pend_ext               = '0;
        pend_ext[NUM_CH-1:0]   = pend;
        cfg_ready              = ~pend_ext[cfg_ch];
        ch_we                  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_we[i] = cfg_valid && cfg_ready && (cfg_ch == CHW'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .cfg_we_i  (ch_we[g]),
            .cfg_div_i (cfg_div),
            .pending_o (pend[g]),
            .ce_o      (ce_o[g]),
            .clk_div_o (clk_div_o[g])
        );
    end

    // Reset sequencer: hold all channels, then release them one per STAGGER
    // cycles starting with channel 0; ready rises with the last release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            idx_q      <= '0;
            hold_q     <= '1;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HCW'(RESET_CYCLES - 1)) begin
                        hold_cnt_q <= '0;
                        stag_cnt_q <= '0;
                        idx_q      <= CHW'(1);
                        hold_q[0]  <= 1'b0;
                        if (NUM_CH == 1) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HCW'(1);
                    end
                end
                S_RELEASE: begin
                    if (stag_cnt_q == SCW'(STAGGER - 1)) begin
                        stag_cnt_q    <= '0;
                        hold_q[idx_q] <= 1'b0;
                        if (idx_q == CHW'(NUM_CH - 1)) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + CHW'(1);
                        end
                    end else begin
                        stag_cnt_q <= stag_cnt_q + SCW'(1);
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    // Soft-reset pulse per released channel; a new request reloads the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                soft_cnt_q[i] <= '0;
            end
            soft_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (soft_rst_req[i] && !hold_q[i]) begin
                    soft_cnt_q[i] <= HCW'(RESET_CYCLES);
                    soft_q[i]     <= 1'b1;
                end else if (soft_cnt_q[i] != '0) begin
                    soft_cnt_q[i] <= soft_cnt_q[i] - HCW'(1);
                    soft_q[i]     <= (soft_cnt_q[i] != HCW'(1));
                end else begin
                    soft_q[i]     <= 1'b0;
                end
            end
        end
    end

    assign rst_o   = hold_q | soft_q;
    assign ready_o = ready_q;

`ifdef CLK_RST_GEN_HEARTBEAT_EN
    logic [HB_BITS-1:0] hb_cnt_q;
    logic               hb_q;

    // Heartbeat: toggle after every 2^HB_BITS channel-0 enables, low in reset.
    always_ff @(posedge clk) begin
        if (rst || rst_o[0]) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (ce_o[0]) begin
            hb_cnt_q <= hb_cnt_q + HB_BITS'(1);
            if (hb_cnt_q == '1) begin
                hb_q <= ~hb_q;
            end
        end
    end

    assign heartbeat_o = hb_q;
`endif

endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: directed bench for clk_rst_gen in its default
// configuration (2 channels, div 1, 20-cycle hold, stagger 4).
module tb_clk_rst_gen;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [1:0]  soft_rst_req;
    logic [1:0]  clk_div_o;
    logic [1:0]  ce_o;
    logic [1:0]  rst_o;
    logic        ready_o;
`ifdef CLK_RST_GEN_HEARTBEAT_EN
    logic        heartbeat;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    clk_rst_gen #(
        .NUM_CH       (2),
        .DIV_W        (16),
        .DEFAULT_DIV  (1),
        .RESET_CYCLES (20),
        .STAGGER      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_div      (cfg_div),
        .soft_rst_req (soft_rst_req),
        .clk_div_o    (clk_div_o),
        .ce_o         (ce_o),
        .rst_o        (rst_o),
        .ready_o      (ready_o)
`ifdef CLK_RST_GEN_HEARTBEAT_EN
        ,
        .heartbeat_o  (heartbeat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: outputs are sampled on the falling edge after each rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (clk_div_o !== 2'b00) begin errors++; $display("FAIL reset_clk_div got=%b exp=00", clk_div_o); end
        checks++; if (ce_o !== 2'b00) begin errors++; $display("FAIL reset_ce got=%b exp=00", ce_o); end
        checks++; if (rst_o !== 2'b11) begin errors++; $display("FAIL reset_rst_o got=%b exp=11", rst_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        cfg_ch = 1'b0; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready0 got=%b exp=1", cfg_ready); end
        cfg_ch = 1'b1; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready1 got=%b exp=1", cfg_ready); end
    endtask

    // Expects rst low since the last falling edge and cyc == 0.
    task automatic test_release();
        logic [1:0] exp_rst;
        logic [1:0] exp_clk;
        logic       exp_rdy;
        for (int k = 1; k <= 24; k++) begin
            soft_rst_req = ((k >= 5 && k <= 8) || k == 21 || k == 22) ? 2'b10 : 2'b00;
            step();
            exp_rst = (k < 20) ? 2'b11 : ((k < 24) ? 2'b10 : 2'b00);
            exp_rdy = (k >= 24);
            exp_clk = (k % 2 == 1) ? 2'b11 : 2'b00;
            checks++; if (rst_o !== exp_rst) begin errors++; $display("FAIL release_rst_o k=%0d got=%b exp=%b", k, rst_o, exp_rst); end
            checks++; if (ready_o !== exp_rdy) begin errors++; $display("FAIL release_ready k=%0d got=%b exp=%b", k, ready_o, exp_rdy); end
            checks++; if (clk_div_o !== exp_clk) begin errors++; $display("FAIL release_clk_div k=%0d got=%b exp=%b", k, clk_div_o, exp_clk); end
            checks++; if (ce_o !== 2'b11) begin errors++; $display("FAIL release_ce k=%0d got=%b exp=11", k, ce_o); end
        end
        soft_rst_req = 2'b00;
    endtask

    // Starts right after edge 24: channel 1 goes to half-period 3.
    task automatic test_cfg_div3();
        logic exp_c1;
        logic exp_e1;
        logic exp_c0;
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd3; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div3_ready_pre got=%b exp=1", cfg_ready); end
        step();
        cfg_valid = 1'b0; #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL div3_ready_pending got=%b exp=0", cfg_ready); end
        checks++; if (clk_div_o[1] !== 1'b1) begin errors++; $display("FAIL div3_clk1_accept got=%b exp=1", clk_div_o[1]); end
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL div3_ready_applied got=%b exp=1", cfg_ready); end
        checks++; if ({ce_o[1], clk_div_o[1]} !== 2'b10) begin errors++; $display("FAIL div3_apply ce1/clk1 got=%b exp=10", {ce_o[1], clk_div_o[1]}); end
        for (int n = 1; n <= 12; n++) begin
            step();
            exp_e1 = (n % 3 == 0);
            exp_c1 = ((n / 3) % 2 == 1);
            exp_c0 = (cyc % 2 == 1);
            checks++; if (ce_o[1] !== exp_e1) begin errors++; $display("FAIL div3_ce1 n=%0d got=%b exp=%b", n, ce_o[1], exp_e1); end
            checks++; if (clk_div_o[1] !== exp_c1) begin errors++; $display("FAIL div3_clk1 n=%0d got=%b exp=%b", n, clk_div_o[1], exp_c1); end
            checks++; if ({ce_o[0], clk_div_o[0]} !== {1'b1, exp_c0}) begin errors++; $display("FAIL div3_ch0 n=%0d got=%b exp=%b", n, {ce_o[0], clk_div_o[0]}, {1'b1, exp_c0}); end
        end
    endtask

    // Starts right after a channel-1 terminal count with half-period 3.
    task automatic test_cfg_pending();
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd100; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL pend_ready_first got=%b exp=1", cfg_ready); end
        step();
        cfg_div = 16'd2; #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_ready_blocked got=%b exp=0", cfg_ready); end
        step();
        checks++; if ({cfg_ready, ce_o[1]} !== 2'b00) begin errors++; $display("FAIL pend_wait ready/ce1 got=%b exp=00", {cfg_ready, ce_o[1]}); end
        step();
        checks++; if ({cfg_ready, ce_o[1], clk_div_o[1]} !== 3'b111) begin errors++; $display("FAIL pend_apply100 ready/ce1/clk1 got=%b exp=111", {cfg_ready, ce_o[1], clk_div_o[1]}); end
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pend_second_accept got=%b exp=0", cfg_ready); end
        for (int n = 1; n <= 98; n++) begin
            step();
            checks++; if ({ce_o[1], clk_div_o[1]} !== 2'b01) begin errors++; $display("FAIL pend_long_period n=%0d ce1/clk1 got=%b exp=01", n, {ce_o[1], clk_div_o[1]}); end
        end
        step();
        checks++; if ({cfg_ready, ce_o[1], clk_div_o[1]} !== 3'b110) begin errors++; $display("FAIL pend_apply2 ready/ce1/clk1 got=%b exp=110", {cfg_ready, ce_o[1], clk_div_o[1]}); end
        step();
        checks++; if ({ce_o[1], clk_div_o[1]} !== 2'b00) begin errors++; $display("FAIL pend_div2_mid ce1/clk1 got=%b exp=00", {ce_o[1], clk_div_o[1]}); end
        step();
        checks++; if ({ce_o[1], clk_div_o[1]} !== 2'b11) begin errors++; $display("FAIL pend_div2_tc ce1/clk1 got=%b exp=11", {ce_o[1], clk_div_o[1]}); end
    endtask

    task automatic test_soft_reset();
        soft_rst_req = 2'b10;
        step();
        soft_rst_req = 2'b00;
        checks++; if ({rst_o, ready_o} !== 3'b101) begin errors++; $display("FAIL soft_start rst_o/ready got=%b exp=101", {rst_o, ready_o}); end
        for (int n = 1; n <= 20; n++) begin
            step();
            checks++; if ({rst_o, ready_o} !== ((n < 20) ? 3'b101 : 3'b001)) begin errors++; $display("FAIL soft_pulse n=%0d rst_o/ready got=%b", n, {rst_o, ready_o}); end
        end
        soft_rst_req = 2'b10;
        step();
        soft_rst_req = 2'b00;
        for (int n = 1; n <= 30; n++) begin
            if (n == 10) soft_rst_req = 2'b10;
            step();
            soft_rst_req = 2'b00;
            checks++; if ({rst_o, ready_o} !== ((n < 30) ? 3'b101 : 3'b001)) begin errors++; $display("FAIL soft_retrigger n=%0d rst_o/ready got=%b", n, {rst_o, ready_o}); end
        end
    endtask

    // Channel 1 at half-period 2, right after its terminal count.
    task automatic test_cfg_zero();
        cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd0; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got=%b exp=1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        soft_rst_req = 2'b10;
        checks++; if ({cfg_ready, ce_o[1]} !== 2'b00) begin errors++; $display("FAIL zero_pending ready/ce1 got=%b exp=00", {cfg_ready, ce_o[1]}); end
        step();
        soft_rst_req = 2'b00;
        checks++; if ({cfg_ready, ce_o[1], clk_div_o[1], rst_o, ready_o} !== 6'b110101) begin errors++; $display("FAIL zero_apply_soft got=%b exp=110101", {cfg_ready, ce_o[1], clk_div_o[1], rst_o, ready_o}); end
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++; if ({ce_o[1], clk_div_o[1], rst_o} !== {1'b1, (n % 2 == 1), 2'b10}) begin errors++; $display("FAIL zero_as_div1 n=%0d ce1/clk1/rst_o got=%b", n, {ce_o[1], clk_div_o[1], rst_o}); end
        end
    endtask

    task automatic test_rst_mid();
        cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd5;
        step();
        cfg_valid = 1'b0;
        step();
        step();
        step();
        checks++; if (ce_o[0] !== 1'b0) begin errors++; $display("FAIL mid_divide_ce0 got=%b exp=0", ce_o[0]); end
        rst = 1'b1;
        step();
        checks++; if ({clk_div_o, ce_o, rst_o, ready_o} !== 7'b0000110) begin errors++; $display("FAIL mid_divide_reset got=%b exp=0000110", {clk_div_o, ce_o, rst_o, ready_o}); end
        cfg_ch = 1'b1; #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mid_divide_cfg_ready got=%b exp=1", cfg_ready); end
        rst = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 21; k++) begin
            step();
            if (k <= 2) begin
                checks++; if ({ce_o, clk_div_o} !== {2'b11, (k == 1) ? 2'b11 : 2'b00}) begin errors++; $display("FAIL restart_div1 k=%0d ce/clk got=%b", k, {ce_o, clk_div_o}); end
            end
        end
        checks++; if ({rst_o, ready_o} !== 3'b100) begin errors++; $display("FAIL restart_release0 got=%b exp=100", {rst_o, ready_o}); end
        rst = 1'b1;
        step();
        checks++; if ({clk_div_o, ce_o, rst_o, ready_o} !== 7'b0000110) begin errors++; $display("FAIL release_reset got=%b exp=0000110", {clk_div_o, ce_o, rst_o, ready_o}); end
        rst = 1'b0;
        cyc = 0;
        test_release();
    endtask

    initial begin
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_ch       = 1'b0;
        cfg_div      = 16'd0;
        soft_rst_req = 2'b00;
        test_reset();
        rst = 1'b0;
        cyc = 0;
        test_release();
        test_cfg_div3();
        test_cfg_pending();
        test_soft_reset();
        test_cfg_zero();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
